// File: rtl/seq_pkg.sv
// ============================================================================
// Module : seq_pkg
// Brief  : Shared state encoding and default widths for the operand sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

  localparam int c_def_w     = 8;
  localparam int c_def_res_w = 16;

  // Encodings are visible on the LEDs through state_o, so they are fixed.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_SHOW  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// Module : button_debounce
// Brief  : 2-FF synchronizer, stable-level debounce and rising-edge pulse.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module button_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int c_cnt_w = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_level;
  logic               r_level_d;
  logic               r_pulse;
  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_pulse   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_pulse   <= r_level & ~r_level_d;
      // Any sample matching the current level restarts the stability count.
      if (r_sync2 != r_level) begin
        if (r_cnt == c_cnt_last) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + c_cnt_one;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/operand_sequencer.sv
// ============================================================================
// Module : operand_sequencer
// Brief  : Latches operands on GO, starts the datapath, holds its result.
//          Optional WAIT timeout enabled by defining TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module operand_sequencer
  import seq_pkg::*;
#(
  parameter int W              = c_def_w,
  parameter int RES_W          = c_def_res_w,
  parameter int DB_CYCLES      = 50000,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  input  logic             btn_go,
  input  logic             btn_clr,
  output logic [W-1:0]     dp_a,
  output logic [W-1:0]     dp_b,
  output logic             dp_start,
  input  logic             dp_done,
  input  logic [RES_W-1:0] dp_result,
  output logic [RES_W-1:0] result,
  output logic             result_ok,
  output logic             busy,
  output logic             error,
  output logic [2:0]       state_o
);

  logic w_go_p;
  logic w_clr_p;

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_go (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_go),
    .pulse (w_go_p)
  );

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_clr),
    .pulse (w_clr_p)
  );

  state_t           r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_start;
  logic             r_busy;
  logic [RES_W-1:0] r_result;
  logic             r_ok;

`ifdef TIMEOUT_EN
  localparam int c_to_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES);
  localparam logic [c_to_w-1:0] c_to_one  = c_to_w'(1);

  logic [c_to_w-1:0] r_wait_cnt;
  logic              r_error;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
      r_result <= '0;
      r_ok     <= 1'b0;
`ifdef TIMEOUT_EN
      r_wait_cnt <= '0;
      r_error    <= 1'b0;
`endif
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_clr_p && w_go_p) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_clr_p) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
`ifdef TIMEOUT_EN
            r_wait_cnt <= c_to_one;
`endif
          end
        end
        S_WAIT: begin
          // An abort wins over a completion arriving in the same cycle.
          if (w_clr_p) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
`ifdef TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end else if (dp_done) begin
            r_result <= dp_result;
            r_ok     <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_SHOW;
`ifdef TIMEOUT_EN
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == c_to_last) begin
            r_ok       <= 1'b0;
            r_busy     <= 1'b0;
            r_error    <= 1'b1;
            r_wait_cnt <= '0;
            r_state    <= S_ERR;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_to_one;
`endif
          end
        end
        S_SHOW: begin
          if (w_clr_p) begin
            r_result <= '0;
            r_ok     <= 1'b0;
            r_state  <= S_IDLE;
          end else if (w_go_p) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_ok    <= 1'b0;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_ERR: begin
          if (w_clr_p) begin
            r_state <= S_IDLE;
`ifdef TIMEOUT_EN
            r_error <= 1'b0;
`endif
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dp_a      = r_a;
  assign dp_b      = r_b;
  assign dp_start  = r_start;
  assign result    = r_result;
  assign result_ok = r_ok;
  assign busy      = r_busy;
  assign state_o   = r_state;

`ifdef TIMEOUT_EN
  assign error = r_error;
`else
  assign error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_operand_sequencer.sv
// ============================================================================
// Module : tb_operand_sequencer
// Brief  : Self-checking bench: vector table, corner sequences, random ops.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_operand_sequencer;

  localparam int W   = 8;
  localparam int RW  = 16;
  localparam int DB  = 4;
  localparam int TO  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  a_in = '0;
  logic [W-1:0]  b_in = '0;
  logic          btn_go = 1'b0;
  logic          btn_clr = 1'b0;
  logic [W-1:0]  dp_a;
  logic [W-1:0]  dp_b;
  logic          dp_start;
  logic          dp_done = 1'b0;
  logic [RW-1:0] dp_result = '0;
  logic [RW-1:0] result;
  logic          result_ok;
  logic          busy;
  logic          error;
  logic [2:0]    state_o;

  always #5 clk = ~clk;

  operand_sequencer #(
    .W(W), .RES_W(RW), .DB_CYCLES(DB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
    .btn_go(btn_go), .btn_clr(btn_clr),
    .dp_a(dp_a), .dp_b(dp_b), .dp_start(dp_start),
    .dp_done(dp_done), .dp_result(dp_result),
    .result(result), .result_ok(result_ok), .busy(busy),
    .error(error), .state_o(state_o)
  );

  int total = 0;
  int bad   = 0;
  int n_start = 0;

  // Reference of what the display should hold: the last completed product.
  logic [RW-1:0] m_res = '0;
  logic          m_ok  = 1'b0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          dly;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [5];

  always @(posedge clk) if (dp_start === 1'b1) n_start <= n_start + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_start(input int budget, input string tag);
    int n = 0;
    while (dp_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_start_seen"}, 32'(dp_start), 32'd1);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state_o !== s && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_state_reached"}, 32'(state_o), 32'(s));
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int dly,
                        input logic [15:0] exp, input string tag);
    a_in = a;
    b_in = b;
    btn_go = 1'b1;
    wait_start(40, tag);
    btn_go = 1'b0;
    a_in = ~a;
    b_in = ~b;
    check({tag, "_dp_a"}, 32'(dp_a), 32'(a));
    check({tag, "_dp_b"}, 32'(dp_b), 32'(b));
    check({tag, "_start_state"}, 32'(state_o), 32'd1);
    check({tag, "_start_busy"}, 32'(busy), 32'd1);
    check({tag, "_start_ok"}, 32'(result_ok), 32'd0);
    tick();
    check({tag, "_start_one_cycle"}, 32'(dp_start), 32'd0);
    check({tag, "_wait_state"}, 32'(state_o), 32'd2);
    repeat (dly - 1) tick();
    dp_result = exp;
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    dp_result = 16'($urandom);
    m_res = exp;
    m_ok  = 1'b1;
    check({tag, "_show_state"}, 32'(state_o), 32'd3);
    check({tag, "_result"}, 32'(result), 32'(m_res));
    check({tag, "_result_ok"}, 32'(result_ok), 32'(m_ok));
    check({tag, "_show_busy"}, 32'(busy), 32'd0);
    repeat (DB + 6) tick();
    check({tag, "_result_held"}, 32'(result), 32'(m_res));
  endtask

  task automatic run_abort(input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] stray, input string tag);
    a_in = a;
    b_in = b;
    btn_go = 1'b1;
    wait_start(40, tag);
    btn_go = 1'b0;
    tick();
    check({tag, "_in_wait"}, 32'(state_o), 32'd2);
    btn_clr = 1'b1;
    wait_state(3'd0, 40, tag);
    btn_clr = 1'b0;
    m_ok = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd0);
    dp_result = stray;
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    check({tag, "_result"}, 32'(result), 32'(m_res));
    check({tag, "_result_ok"}, 32'(result_ok), 32'(m_ok));
    check({tag, "_idle"}, 32'(state_o), 32'd0);
    repeat (DB + 6) tick();
  endtask

  task automatic press_clr_to_idle(input string tag);
    btn_clr = 1'b1;
    wait_state(3'd0, 40, tag);
    btn_clr = 1'b0;
    repeat (DB + 6) tick();
  endtask

  initial begin
    int n0;
    logic [7:0] ra;
    logic [7:0] rb;

    tbl[0] = '{8'h0F, 8'h03, 3, 16'h002D};
    tbl[1] = '{8'hFF, 8'hFF, 1, 16'hFE01};
    tbl[2] = '{8'h00, 8'h7B, 2, 16'h0000};
    tbl[3] = '{8'h80, 8'h02, 5, 16'h0100};
    tbl[4] = '{8'hA5, 8'h01, 4, 16'h00A5};

    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_outputs", {dp_a, dp_b, 6'd0, dp_start, busy, error, result_ok},
          32'd0);
    check("rst_result", 32'(result), 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 5; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].dly, tbl[i].exp, $sformatf("vec%0d", i));

    // Bouncy GO: toggling every 2 cycles never settles, final hold gives one start.
    n0 = n_start;
    a_in = 8'h21;
    b_in = 8'h02;
    for (int i = 0; i < 6; i++) begin
      btn_go = ~btn_go;
      tick();
      tick();
    end
    btn_go = 1'b1;
    wait_start(40, "bounce");
    tick();
    dp_result = 16'h0042;
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    m_res = 16'h0042;
    m_ok = 1'b1;
    repeat (20) tick();
    check("bounce_one_start", 32'(n_start - n0), 32'd1);
    check("bounce_show", 32'(state_o), 32'd3);
    check("bounce_result", 32'(result), 32'(m_res));
    btn_go = 1'b0;
    repeat (DB + 6) tick();

    // GO and CLR together in SHOW: CLR wins.
    n0 = n_start;
    btn_go = 1'b1;
    btn_clr = 1'b1;
    repeat (DB + 10) tick();
    m_res = '0;
    m_ok = 1'b0;
    check("both_idle", 32'(state_o), 32'd0);
    check("both_result", 32'(result), 32'(m_res));
    check("both_ok", 32'(result_ok), 32'(m_ok));
    check("both_no_start", 32'(n_start - n0), 32'd0);
    btn_go = 1'b0;
    btn_clr = 1'b0;
    repeat (DB + 6) tick();

    run_abort(8'h11, 8'h22, 16'hBEEF, "abort");

    // Asynchronous reset in the middle of WAIT.
    a_in = 8'h12;
    b_in = 8'h34;
    btn_go = 1'b1;
    wait_start(40, "rstwait");
    btn_go = 1'b0;
    tick();
    check("rstwait_in_wait", 32'(state_o), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("rstwait_state", 32'(state_o), 32'd0);
    check("rstwait_outputs", {dp_a, dp_b, 6'd0, dp_start, busy, error, result_ok},
          32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) tick();
    m_res = '0;
    m_ok = 1'b0;
    run_op(8'h12, 8'h34, 2, 16'h03A8, "post_rst");

    a_in = 8'h05;
    b_in = 8'h06;
    btn_go = 1'b1;
    wait_start(40, "nodone");
    btn_go = 1'b0;
`ifdef TIMEOUT_EN
    repeat (TO) tick();
    check("to_still_wait", 32'(state_o), 32'd2);
    check("to_no_error_yet", 32'(error), 32'd0);
    tick();
    check("to_err_state", 32'(state_o), 32'd4);
    check("to_error", 32'(error), 32'd1);
    check("to_ok", 32'(result_ok), 32'd0);
    check("to_busy", 32'(busy), 32'd0);
    press_clr_to_idle("to_clr");
    check("to_error_cleared", 32'(error), 32'd0);
`else
    repeat (3 * TO) tick();
    check("nodone_still_wait", 32'(state_o), 32'd2);
    check("nodone_error", 32'(error), 32'd0);
    press_clr_to_idle("nodone_clr");
`endif
    m_ok = 1'b0;
    check("nodone_ok", 32'(result_ok), 32'(m_ok));
    check("nodone_result", 32'(result), 32'(m_res));

    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 3) == 0)
        run_abort(ra, rb, 16'($urandom), $sformatf("rnd%0d_abort", i));
      else
        run_op(ra, rb, int'($urandom_range(1, 5)), 16'(ra) * 16'(rb),
               $sformatf("rnd%0d_op", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
